ws_task_queue_array: RTL and testbench

Parametrised array of per-pipeline task queues with integrated work stealing. It is the next-generation replacement for the fixed 16-pipeline queue/stealing pair in the WS-RPE datapath. Each PE lane pushes block tasks into its own queue and pops from it. A lane whose queue is empty steals from the tail of another lane's queue, one steal per cycle, using a selectable victim policy. Steal statistics and failure pulses feed the redundant-PE mapper and the dynamic adjustment unit.

---
 rtl/ws_task_queue_array.sv | 183 ++++++++++++++++++
 tb/tb_ws_task_queue_array.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_task_queue_array.sv
// Array of per-lane circular task queues with round-robin thief arbitration and
// LIFO work stealing from the tail of a selected victim queue.
module ws_task_queue_array #(
    parameter int NUM_QUEUES      = 16,
    parameter int QUEUE_DEPTH     = 16,
    parameter int TASK_WIDTH      = 32,
    parameter int STEAL_THRESHOLD = 2,
    parameter int CNT_W           = $clog2(QUEUE_DEPTH) + 1,
    parameter int IDX_W           = $clog2(NUM_QUEUES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_QUEUES-1:0]          push_valid,
    input  logic [NUM_QUEUES*TASK_WIDTH-1:0] push_data,
    output logic [NUM_QUEUES-1:0]          push_ready,
    input  logic [NUM_QUEUES-1:0]          pop_req,
    output logic [NUM_QUEUES-1:0]          pop_valid,
    output logic [NUM_QUEUES*TASK_WIDTH-1:0] pop_data,
    output logic [NUM_QUEUES-1:0]          pop_stolen,
    input  logic                           steal_en,
    input  logic                           steal_mode,
    input  logic                           flush,
    output logic [NUM_QUEUES*CNT_W-1:0]    queue_count,
    output logic                           steal_valid,
    output logic [IDX_W-1:0]               steal_src,
    output logic [IDX_W-1:0]               steal_dst,
    output logic                           steal_failed,
    output logic [15:0]                    steal_total
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    logic [CNT_W-1:0]      count_q   [NUM_QUEUES];
    logic [TASK_WIDTH-1:0] tail_word [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] local_pop, thief_req, eligible, stolen_from, steal_to;
    logic                  thief_any, victim_found, steal_go;
    logic [IDX_W-1:0]      thief_idx, victim_idx;
    logic [CNT_W-1:0]      best_cnt;
    logic [TASK_WIDTH-1:0] steal_word;

    logic                  steal_valid_reg, steal_failed_reg;
    logic [IDX_W-1:0]      steal_src_reg, steal_dst_reg, rr_thief_reg, rr_victim_reg;
    logic [15:0]           steal_total_reg;

    function automatic logic [IDX_W-1:0] lane_at(input logic [IDX_W-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= NUM_QUEUES) j = j - NUM_QUEUES;
        return IDX_W'(j);
    endfunction

    always_comb begin
        thief_any = 1'b0;
        thief_idx = '0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            if (!thief_any && thief_req[lane_at(rr_thief_reg, k)]) begin
                thief_any = 1'b1;
                thief_idx = lane_at(rr_thief_reg, k);
            end
        end

        eligible = '0;
        for (int j = 0; j < NUM_QUEUES; j++) begin
            eligible[j] = (count_q[j] >= CNT_W'(STEAL_THRESHOLD)) && (IDX_W'(j) != thief_idx)
                          && !push_valid[j] && !flush;
        end

        victim_found = 1'b0;
        victim_idx   = '0;
        best_cnt     = '0;
        if (!steal_mode) begin
            // strict compare keeps the lowest index on ties
            for (int j = 0; j < NUM_QUEUES; j++) begin
                if (eligible[j] && (!victim_found || count_q[j] > best_cnt)) begin
                    victim_found = 1'b1;
                    victim_idx   = IDX_W'(j);
                    best_cnt     = count_q[j];
                end
            end
        end else begin
            for (int k = 0; k < NUM_QUEUES; k++) begin
                if (!victim_found && eligible[lane_at(rr_victim_reg, k)]) begin
                    victim_found = 1'b1;
                    victim_idx   = lane_at(rr_victim_reg, k);
                end
            end
        end

        steal_go   = thief_any && victim_found;
        steal_word = tail_word[victim_idx];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_QUEUES; gi++) begin : gen_lane
            logic [TASK_WIDTH-1:0] mem [QUEUE_DEPTH];
            logic [PTR_W-1:0]      head_reg, tail_reg;
            logic [CNT_W-1:0]      count_reg;
            logic                  pop_valid_reg, pop_stolen_reg, push_acc;
            logic [TASK_WIDTH-1:0] pop_data_reg;

            assign push_ready[gi]  = (count_reg != CNT_W'(QUEUE_DEPTH));
            assign push_acc        = push_valid[gi] && push_ready[gi] && !flush;
            assign local_pop[gi]   = pop_req[gi] && (count_reg != '0) && !flush;
            assign thief_req[gi]   = pop_req[gi] && (count_reg == '0) && steal_en && !flush;
            assign stolen_from[gi] = steal_go && (victim_idx == IDX_W'(gi));
            assign steal_to[gi]    = steal_go && (thief_idx == IDX_W'(gi));
            // newest entry is read combinationally so any lane can be robbed in one cycle
            assign tail_word[gi]   = mem[tail_reg - PTR_W'(1)];
            assign count_q[gi]     = count_reg;

            always_ff @(posedge clk) begin
                if (push_acc) mem[tail_reg] <= push_data[gi*TASK_WIDTH +: TASK_WIDTH];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    head_reg       <= '0;
                    tail_reg       <= '0;
                    count_reg      <= '0;
                    pop_valid_reg  <= 1'b0;
                    pop_stolen_reg <= 1'b0;
                    pop_data_reg   <= '0;
                end else begin
                    pop_valid_reg  <= 1'b0;
                    pop_stolen_reg <= 1'b0;
                    if (flush) begin
                        head_reg  <= '0;
                        tail_reg  <= '0;
                        count_reg <= '0;
                    end else begin
                        // a victim never pushes in the same cycle, so tail moves one way only
                        if (push_acc)             tail_reg <= tail_reg + PTR_W'(1);
                        else if (stolen_from[gi]) tail_reg <= tail_reg - PTR_W'(1);
                        if (local_pop[gi]) begin
                            head_reg      <= head_reg + PTR_W'(1);
                            pop_valid_reg <= 1'b1;
                            pop_data_reg  <= mem[head_reg];
                        end else if (steal_to[gi]) begin
                            pop_valid_reg  <= 1'b1;
                            pop_stolen_reg <= 1'b1;
                            pop_data_reg   <= steal_word;
                        end
                        count_reg <= count_reg + CNT_W'(push_acc) - CNT_W'(local_pop[gi])
                                     - CNT_W'(stolen_from[gi]);
                    end
                end
            end

            assign pop_valid[gi]  = pop_valid_reg;
            assign pop_stolen[gi] = pop_stolen_reg;
            assign pop_data[gi*TASK_WIDTH +: TASK_WIDTH] = pop_data_reg;
            assign queue_count[gi*CNT_W +: CNT_W]        = count_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            steal_valid_reg  <= 1'b0;
            steal_failed_reg <= 1'b0;
            steal_src_reg    <= '0;
            steal_dst_reg    <= '0;
            steal_total_reg  <= '0;
            rr_thief_reg     <= '0;
            rr_victim_reg    <= '0;
        end else begin
            steal_valid_reg  <= steal_go;
            steal_failed_reg <= thief_any && !victim_found;
            if (steal_go) begin
                steal_src_reg <= victim_idx;
                steal_dst_reg <= thief_idx;
                rr_thief_reg  <= lane_at(thief_idx, 1);
                if (steal_mode) rr_victim_reg <= lane_at(victim_idx, 1);
                if (steal_total_reg != 16'hFFFF) steal_total_reg <= steal_total_reg + 16'd1;
            end
        end
    end

    assign steal_valid  = steal_valid_reg;
    assign steal_failed = steal_failed_reg;
    assign steal_src    = steal_src_reg;
    assign steal_dst    = steal_dst_reg;
    assign steal_total  = steal_total_reg;
endmodule

// File: tb/tb_ws_task_queue_array.sv
// Self-checking bench for ws_task_queue_array: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_ws_task_queue_array;
    localparam int N  = 16;
    localparam int D  = 16;
    localparam int TW = 32;
    localparam int TH = 2;
    localparam int CW = 5;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst, steal_en, steal_mode, flush;
    logic [N-1:0]    push_valid, push_ready, pop_req, pop_valid, pop_stolen;
    logic [N*TW-1:0] push_data, pop_data;
    logic [N*CW-1:0] queue_count;
    logic            steal_valid, steal_failed;
    logic [IW-1:0]   steal_src, steal_dst;
    logic [15:0]     steal_total;

    always #5 clk = ~clk;

    ws_task_queue_array #(.NUM_QUEUES(N), .QUEUE_DEPTH(D), .TASK_WIDTH(TW),
                          .STEAL_THRESHOLD(TH)) dut (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .pop_req(pop_req), .pop_valid(pop_valid),
        .pop_data(pop_data), .pop_stolen(pop_stolen), .steal_en(steal_en),
        .steal_mode(steal_mode), .flush(flush), .queue_count(queue_count),
        .steal_valid(steal_valid), .steal_src(steal_src), .steal_dst(steal_dst),
        .steal_failed(steal_failed), .steal_total(steal_total));

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: one SV queue per lane, front = oldest, back = newest
    logic [TW-1:0]   mq [N][$];
    int              rr_t, rr_v, m_total, m_src, m_dst;
    logic [N-1:0]    exp_pv, exp_ps, exp_ready;
    logic            exp_sv, exp_sf;
    logic [N*TW-1:0] exp_pdp, pd_mask;
    logic [N*CW-1:0] exp_qc;

    task automatic model_step();
        int cnt [N];
        int thief, victim, best, j;
        exp_pv = '0; exp_ps = '0; exp_sv = 1'b0; exp_sf = 1'b0; pd_mask = '0;
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            rr_t = 0; rr_v = 0; m_total = 0; m_src = 0; m_dst = 0;
            exp_pdp = '0; pd_mask = '1;
        end else if (flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < N; i++) cnt[i] = mq[i].size();
            for (int i = 0; i < N; i++) begin
                if (pop_req[i] && cnt[i] > 0) begin
                    exp_pdp[i*TW +: TW] = mq[i].pop_front();
                    exp_pv[i] = 1'b1;
                    pd_mask[i*TW +: TW] = '1;
                end
            end
            thief = -1;
            for (int k = 0; k < N; k++) begin
                j = (rr_t + k) % N;
                if (thief < 0 && steal_en && pop_req[j] && cnt[j] == 0) thief = j;
            end
            if (thief >= 0) begin
                victim = -1; best = -1;
                for (int k = 0; k < N; k++) begin
                    j = steal_mode ? (rr_v + k) % N : k;
                    if (j != thief && cnt[j] >= TH && !push_valid[j]) begin
                        if (steal_mode ? (victim < 0) : (cnt[j] > best)) begin
                            victim = j; best = cnt[j];
                        end
                    end
                end
                if (victim < 0) exp_sf = 1'b1;
                else begin
                    exp_pdp[thief*TW +: TW] = mq[victim].pop_back();
                    exp_pv[thief] = 1'b1; exp_ps[thief] = 1'b1;
                    pd_mask[thief*TW +: TW] = '1;
                    exp_sv = 1'b1; m_src = victim; m_dst = thief;
                    rr_t = (thief + 1) % N;
                    if (steal_mode) rr_v = (victim + 1) % N;
                    if (m_total < 65535) m_total++;
                end
            end
            for (int i = 0; i < N; i++)
                if (push_valid[i] && cnt[i] < D) mq[i].push_back(push_data[i*TW +: TW]);
        end
        for (int i = 0; i < N; i++) begin
            exp_qc[i*CW +: CW] = CW'(mq[i].size());
            exp_ready[i] = (mq[i].size() < D);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push_valid = '0; push_data = '0; pop_req = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs(); steal_en = 1'b0; steal_mode = 1'b0;
        cycle(); cycle();
        n_cmp++; if (push_ready !== {N{1'b1}}) begin n_bad++; $display("FAIL reset_push_ready got %h want %h", push_ready, {N{1'b1}}); end
        n_cmp++; if (pop_valid !== '0 || pop_stolen !== '0) begin n_bad++; $display("FAIL reset_pop got %h/%h want 0/0", pop_valid, pop_stolen); end
        n_cmp++; if (queue_count !== '0 || pop_data !== '0) begin n_bad++; $display("FAIL reset_count_data got %h/%h want 0", queue_count, pop_data); end
        n_cmp++; if ({steal_valid, steal_failed, steal_src, steal_dst, steal_total} !== '0) begin
            n_bad++; $display("FAIL reset_steal got v%b f%b s%0d d%0d t%0d want 0", steal_valid, steal_failed, steal_src, steal_dst, steal_total); end
        rst = 1'b0;
    endtask

    task automatic test_fifo_order();
        idle_inputs(); steal_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_valid = '0; push_valid[3] = 1'b1; push_data[3*TW +: TW] = 32'hA0 + k;
            cycle();
        end
        idle_inputs(); pop_req[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            $display("pop lane3 data=%h stolen=%b count=%0d", pop_data[3*TW +: TW], pop_stolen[3], queue_count[3*CW +: CW]);
            n_cmp++; if (pop_valid[3] !== 1'b1 || pop_stolen[3] !== 1'b0) begin n_bad++; $display("FAIL fifo_valid got %b/%b want 1/0", pop_valid[3], pop_stolen[3]); end
            n_cmp++; if (pop_data[3*TW +: TW] !== 32'hA0 + k) begin n_bad++; $display("FAIL fifo_data got %h want %h", pop_data[3*TW +: TW], 32'hA0 + k); end
            n_cmp++; if (queue_count[3*CW +: CW] !== CW'(4 - k)) begin n_bad++; $display("FAIL fifo_count got %0d want %0d", queue_count[3*CW +: CW], 4 - k); end
        end
        idle_inputs(); cycle();
    endtask

    task automatic test_full();
        idle_inputs(); steal_en = 1'b0;
        for (int k = 0; k < 17; k++) begin
            push_valid[0] = 1'b1; push_data[TW-1:0] = 32'h100 + k;
            cycle();
        end
        idle_inputs();
        n_cmp++; if (push_ready[0] !== 1'b0 || queue_count[CW-1:0] !== CW'(16)) begin
            n_bad++; $display("FAIL full_state got ready=%b count=%0d want 0/16", push_ready[0], queue_count[CW-1:0]); end
        pop_req[0] = 1'b1;
        for (int k = 0; k < 17; k++) begin
            cycle();
            if (k < 16) begin
                $display("pop lane0 data=%h", pop_data[TW-1:0]);
                n_cmp++; if (pop_valid[0] !== 1'b1 || pop_data[TW-1:0] !== 32'h100 + k) begin
                    n_bad++; $display("FAIL full_drain got v=%b %h want 1 %h", pop_valid[0], pop_data[TW-1:0], 32'h100 + k); end
            end else begin
                n_cmp++; if (pop_valid[0] !== 1'b0) begin n_bad++; $display("FAIL full_17th got v=%b want 0", pop_valid[0]); end
            end
        end
        idle_inputs(); cycle();
    endtask

    task automatic test_steal_max();
        rst = 1'b1; idle_inputs(); cycle(); rst = 1'b0;
        steal_en = 1'b1; steal_mode = 1'b0;
        for (int c = 0; c < 6; c++) begin
            push_valid = '0;
            push_valid[2] = (c < 3); push_valid[5] = 1'b1; push_valid[7] = 1'b1;
            push_data[2*TW +: TW] = 32'h200 + c; push_data[5*TW +: TW] = 32'h500 + c;
            push_data[7*TW +: TW] = 32'h700 + c;
            cycle();
        end
        idle_inputs(); pop_req[1] = 1'b1;
        cycle();
        $display("steal %0d -> %0d data=%h", steal_src, steal_dst, pop_data[TW +: TW]);
        n_cmp++; if (steal_valid !== 1'b1 || steal_src !== 4'd5 || steal_dst !== 4'd1) begin
            n_bad++; $display("FAIL max_victim got v=%b src=%0d dst=%0d want 1/5/1", steal_valid, steal_src, steal_dst); end
        n_cmp++; if (pop_valid[1] !== 1'b1 || pop_stolen[1] !== 1'b1 || pop_data[TW +: TW] !== 32'h505) begin
            n_bad++; $display("FAIL max_data got v=%b s=%b %h want 1/1/505", pop_valid[1], pop_stolen[1], pop_data[TW +: TW]); end
        n_cmp++; if (queue_count[5*CW +: CW] !== CW'(5)) begin n_bad++; $display("FAIL max_count got %0d want 5", queue_count[5*CW +: CW]); end
        idle_inputs(); cycle();
    endtask

    task automatic test_steal_rr();
        rst = 1'b1; idle_inputs(); cycle(); rst = 1'b0;
        steal_en = 1'b1; steal_mode = 1'b1;
        for (int c = 0; c < 4; c++) begin
            push_valid = '0; push_valid[1] = 1'b1; push_valid[2] = 1'b1;
            push_data[TW +: TW] = 32'h110 + c; push_data[2*TW +: TW] = 32'h220 + c;
            cycle();
        end
        idle_inputs(); pop_req[0] = 1'b1; pop_req[3] = 1'b1;
        cycle();
        $display("steal %0d -> %0d data=%h", steal_src, steal_dst, pop_data[0 +: TW]);
        n_cmp++; if (steal_valid !== 1'b1 || steal_src !== 4'd1 || steal_dst !== 4'd0 || pop_data[0 +: TW] !== 32'h113) begin
            n_bad++; $display("FAIL rr_first got src=%0d dst=%0d %h want 1/0/113", steal_src, steal_dst, pop_data[0 +: TW]); end
        cycle();
        $display("steal %0d -> %0d data=%h", steal_src, steal_dst, pop_data[3*TW +: TW]);
        n_cmp++; if (steal_valid !== 1'b1 || steal_src !== 4'd2 || steal_dst !== 4'd3 || pop_data[3*TW +: TW] !== 32'h223) begin
            n_bad++; $display("FAIL rr_second got src=%0d dst=%0d %h want 2/3/223", steal_src, steal_dst, pop_data[3*TW +: TW]); end
        n_cmp++; if (steal_total !== 16'd2) begin n_bad++; $display("FAIL rr_total got %0d want 2", steal_total); end
        idle_inputs(); cycle();
    endtask

    task automatic test_steal_fail();
        rst = 1'b1; idle_inputs(); cycle(); rst = 1'b0;
        steal_en = 1'b1; steal_mode = 1'b0;
        push_valid = '0; push_valid[N-1:4] = '1;
        for (int i = 4; i < N; i++) push_data[i*TW +: TW] = 32'h900 + i;
        cycle();
        idle_inputs(); pop_req[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_cmp++; if (steal_failed !== 1'b1 || pop_valid !== '0 || steal_total !== 16'd0) begin
                n_bad++; $display("FAIL steal_fail got f=%b pv=%h t=%0d want 1/0/0", steal_failed, pop_valid, steal_total); end
        end
        idle_inputs(); cycle();
    endtask

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            push_valid = N'($urandom) & N'($urandom);
            for (int i = 0; i < N; i++) push_data[i*TW +: TW] = $urandom;
            pop_req  = N'($urandom) & N'($urandom) & N'($urandom);
            steal_en = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 63) == 0);
            if (c % 50 == 0) steal_mode = $urandom_range(0, 1);
            cycle();
            if (exp_sv) $display("steal %0d -> %0d data=%h", m_src, m_dst, exp_pdp[m_dst*TW +: TW]);
            n_cmp++; if (pop_valid !== exp_pv) begin n_bad++; $display("FAIL rnd_pop_valid got %h want %h", pop_valid, exp_pv); end
            n_cmp++; if ((pop_stolen & exp_pv) !== exp_ps) begin n_bad++; $display("FAIL rnd_pop_stolen got %h want %h", pop_stolen & exp_pv, exp_ps); end
            n_cmp++; if ((pop_data & pd_mask) !== (exp_pdp & pd_mask)) begin n_bad++; $display("FAIL rnd_pop_data got %h want %h", pop_data & pd_mask, exp_pdp & pd_mask); end
            n_cmp++; if (queue_count !== exp_qc || push_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_count got %h/%h want %h/%h", queue_count, push_ready, exp_qc, exp_ready); end
            n_cmp++; if (steal_valid !== exp_sv || steal_failed !== exp_sf || steal_total !== 16'(m_total)) begin
                n_bad++; $display("FAIL rnd_steal got v%b f%b t%0d want v%b f%b t%0d", steal_valid, steal_failed, steal_total, exp_sv, exp_sf, m_total); end
            n_cmp++; if (steal_src !== IW'(m_src) || steal_dst !== IW'(m_dst)) begin
                n_bad++; $display("FAIL rnd_src_dst got %0d/%0d want %0d/%0d", steal_src, steal_dst, m_src, m_dst); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        test_random(40);
        rst = 1'b1; push_valid = '1; pop_req = N'($urandom); steal_en = 1'b1;
        cycle();
        rst = 1'b0;
        n_cmp++; if (queue_count !== '0 || push_ready !== {N{1'b1}} || pop_data !== '0) begin
            n_bad++; $display("FAIL midrst_state got %h/%h want 0/ffff", queue_count, push_ready); end
        n_cmp++; if (pop_valid !== '0 || pop_stolen !== '0 || steal_valid !== 1'b0 || steal_failed !== 1'b0) begin
            n_bad++; $display("FAIL midrst_pulses got pv=%h ps=%h sv=%b sf=%b want 0", pop_valid, pop_stolen, steal_valid, steal_failed); end
        n_cmp++; if (steal_total !== 16'd0 || steal_src !== '0 || steal_dst !== '0) begin
            n_bad++; $display("FAIL midrst_steal got t=%0d s=%0d d=%0d want 0", steal_total, steal_src, steal_dst); end
        idle_inputs(); steal_en = 1'b0; pop_req = '1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_cmp++; if (pop_valid !== '0 || queue_count !== '0) begin
                n_bad++; $display("FAIL midrst_gone got pv=%h cnt=%h want 0", pop_valid, queue_count); end
        end
        idle_inputs(); cycle();
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_full();
        test_steal_max();
        test_steal_rr();
        test_steal_fail();
        test_random(2000);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
